sine_tone_sequencer: RTL
========================

Name: sine_tone_sequencer

Overview:
Schedules tone bursts onto the two-channel sine datapath. It accepts tone commands (channel, phase step, sample count) through a valid/ready port and buffers them in a small in-order FIFO. It runs one phase-accumulator FSM per channel and shares a single synchronous sine ROM port between both channels with round-robin arbitration. Each channel emits one sample per ROM grant and pulses done at the end of its burst.

Parameters:
DEPTH_P, 11, ROM address bits (table holds 2**DEPTH_P samples)
WIDTH_P, 16, sample amplitude bits
LEN_W, 16, burst length counter bits
FIFO_DEPTH, 4, command FIFO entries (power of 2)

Ports:
clk  in  1  system clock
reset  in  1  asynchronous active-low reset
abort  in  1  synchronous flush of all work
cmd_valid  in  1  command offered
cmd_ready  out  1  FIFO not full
cmd_chan  in  1  target channel (0/1)
cmd_step  in  DEPTH_P  phase increment per sample
cmd_len  in  LEN_W  samples in the burst
rom_en  out  1  ROM read strobe
rom_addr  out  DEPTH_P  ROM address
rom_data  in  WIDTH_P  ROM data, valid the cycle after rom_en
sine_out0, sine_out1  out  WIDTH_P  channel samples
sample_valid0, sample_valid1  out  1  one-cycle sample strobes
busy0, busy1  out  1  channel has a burst in progress
done0, done1  out  1  one-cycle end-of-burst pulses

Behaviour:
- Interface: one clock, clk; reset is asynchronous and active-low.
- Reset (reset=0): FIFO empty, both FSMs IDLE, arbiter pointer = ch1 (ch0 wins the first tie). All outputs are 0. cmd_ready is 1 after release.
- Accept: cmd_valid & cmd_ready at an edge writes the command to the FIFO tail. cmd_ready = !full. It is combinational from FIFO state only and does not depend on cmd_valid.
- Dispatch: the FIFO head pops when its target channel FSM is IDLE. That channel enters RUN at the same edge with phase=0, step=cmd_step, remaining=cmd_len.
- Dispatch order: strictly in order. A head targeting a busy channel blocks later commands (head-of-line blocking is intended). At most one pop per cycle.
- Per-channel FSM states: IDLE, RUN, DRAIN.
  - IDLE -> RUN on dispatch.
  - In RUN, each granted cycle: rom_addr=phase, rom_en=1, phase <= (phase+step) mod 2**DEPTH_P, remaining <= remaining-1.
  - RUN -> DRAIN on the grant with remaining==1.
  - DRAIN -> IDLE when the last sample is output.
- Arbitration: a channel in RUN requests every cycle. A sole requester is granted every cycle. If both request, the grant goes to the channel not granted last. rom_en=0 when neither requests.
- Latency: grant at cycle t, rom_data valid at t+1, sine_outN and sample_validN registered at t+2. sine_outN holds its value between strobes.
- done/busy: doneN pulses in the same cycle as the last sample_validN. busyN=1 from the RUN entry edge until the cycle after doneN. A new command for that channel may dispatch in the done cycle.
- cmd_len==0: the command pops, the channel goes straight to DRAIN, doneN pulses 2 cycles later, and no samples or ROM reads occur.
- Full FIFO: cmd_ready=0; a cmd_valid offered while full is not accepted.
- Simultaneous pop and push on a full FIFO: cmd_ready stays 0 that cycle (no same-cycle bypass).
- abort=1: at the next edge the FIFO is emptied and both FSMs go to IDLE. ROM data still in flight is discarded, with no sample_valid or done. sine_out holds its last value. cmd_ready stays 0 in the abort cycle.
- Reset mid-burst: identical to reset above. The partially emitted burst is lost and no done pulse is issued.

Decomposition:
- Shared package sine_pkg:
  - DEPTH_P/WIDTH_P/LEN_W defaults
  - tone_cmd_t typedef {chan, step, len}
  - chan_state_t enum {IDLE, RUN, DRAIN}
- One sub-module: sine_cmd_fifo, a synchronous FIFO of tone_cmd_t with full/empty flags and a flush input.
- The arbiter and the two channel FSMs stay in the top module.

Test Plan:
- Single burst: ch0, step=1, len=4. Expect rom_addr 0,1,2,3 on consecutive cycles, 4 sample_valid0 strobes starting 2 cycles after the first rom_en, and done0 coincident with the 4th strobe.
- Wrap and arbitration: ch0 step=1024 len=3 plus ch1 step=1 len=3, back-to-back. Expect grants alternating ch0,ch1,…. ch0 addresses are 0,1024,0 (wrap); ch1 addresses are 0,1,2. Each channel outputs one sample every 2 cycles.
- Backpressure: ch0 len=100 running, then push 5 commands to ch0. Expect cmd_ready=0 after the 4th is accepted. The 5th is held until ch0 done0 pops the head.
- Head-of-line blocking: ch0 len=10 running, then FIFO holds [ch0 len=2, ch1 len=2]. Expect ch1 to stay idle until ch0's first burst finishes.
- Zero length: ch1 len=0. Expect no rom_en and no sample_valid1, and done1 exactly 2 cycles after the pop.
- Abort and reset: assert abort during a ch0 len=8 burst after 3 samples. Expect no further sample_valid0, no done0, busy0=0, and FIFO empty. Repeat with reset low: all outputs are 0 immediately (asynchronous).

Source files
------------

// File: rtl/sine_pkg.sv
// Shared widths, command record and channel state encoding for the two-channel
// sine tone sequencer.
package sine_pkg;
    localparam int DEPTH_P = 11;
    localparam int WIDTH_P = 16;
    localparam int LEN_W   = 16;

    typedef struct packed {
        logic               chan;
        logic [DEPTH_P-1:0] step;
        logic [LEN_W-1:0]   len;
    } tone_cmd_t;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2
    } chan_state_t;
endpackage

// File: rtl/sine_tone_sequencer_if.sv
// Command valid/ready port and shared sine ROM port of the tone sequencer.
// The slave side is the sequencer, the master side is its environment.
interface sine_tone_sequencer_if;
    import sine_pkg::*;

    logic               cmd_valid;
    logic               cmd_ready;
    logic               cmd_chan;
    logic [DEPTH_P-1:0] cmd_step;
    logic [LEN_W-1:0]   cmd_len;
    logic               rom_en;
    logic [DEPTH_P-1:0] rom_addr;
    logic [WIDTH_P-1:0] rom_data;

    modport master (
        output cmd_valid, cmd_chan, cmd_step, cmd_len, rom_data,
        input  cmd_ready, rom_en, rom_addr
    );

    modport slave (
        input  cmd_valid, cmd_chan, cmd_step, cmd_len, rom_data,
        output cmd_ready, rom_en, rom_addr
    );
endinterface

// File: rtl/sine_cmd_fifo.sv
// In-order command FIFO with an extra wrap bit on each pointer so full and
// empty are distinguishable; flush empties it at the next edge.
module sine_cmd_fifo
    import sine_pkg::*;
#(
    parameter int FIFO_DEPTH = 4
) (
    input  logic      clk,
    input  logic      rst_n,
    input  logic      i_flush,
    input  logic      i_push,
    input  tone_cmd_t i_din,
    input  logic      i_pop,
    output tone_cmd_t o_dout,
    output logic      o_full,
    output logic      o_empty
);
    localparam int AW = $clog2(FIFO_DEPTH);

    tone_cmd_t     r_mem [FIFO_DEPTH];
    logic [AW:0]   r_wptr, r_rptr;
    logic          w_wr, w_rd;

    assign o_empty = (r_wptr == r_rptr);
    assign o_full  = (r_wptr[AW] != r_rptr[AW]) && (r_wptr[AW-1:0] == r_rptr[AW-1:0]);
    assign o_dout  = r_mem[r_rptr[AW-1:0]];
    assign w_wr    = i_push && !o_full && !i_flush;
    assign w_rd    = i_pop && !o_empty && !i_flush;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wptr <= '0;
            r_rptr <= '0;
        end else if (i_flush) begin
            r_wptr <= '0;
            r_rptr <= '0;
        end else begin
            if (w_wr) r_wptr <= r_wptr + 1'b1;
            if (w_rd) r_rptr <= r_rptr + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (w_wr) r_mem[r_wptr[AW-1:0]] <= i_din;
    end
endmodule

// File: rtl/sine_tone_sequencer.sv
// Two-channel tone burst scheduler: in-order command FIFO, one phase
// accumulator FSM per channel, round-robin sharing of one synchronous ROM port.
module sine_tone_sequencer
    import sine_pkg::*;
#(
    parameter int FIFO_DEPTH = 4
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 abort,
    sine_tone_sequencer_if.slave bus,
    output logic [WIDTH_P-1:0]   sine_out0,
    output logic [WIDTH_P-1:0]   sine_out1,
    output logic                 sample_valid0,
    output logic                 sample_valid1,
    output logic                 busy0,
    output logic                 busy1,
    output logic                 done0,
    output logic                 done1
);
    tone_cmd_t                 w_cmd, w_head;
    logic                      w_full, w_empty, w_push, w_pop;
    logic                      r_alive;
    chan_state_t               r_state [2];
    logic [1:0][DEPTH_P-1:0]   r_phase, r_step;
    logic [1:0][LEN_W-1:0]     r_rem;
    logic [1:0]                w_req, w_gnt;
    logic [1:0]                r_done, r_vld, r_sv;
    logic [1:0][WIDTH_P-1:0]   r_sine;
    logic                      r_last;

    assign w_cmd         = '{chan: bus.cmd_chan, step: bus.cmd_step, len: bus.cmd_len};
    assign bus.cmd_ready = r_alive && !w_full && !abort;
    assign w_push        = bus.cmd_valid && bus.cmd_ready;
    // Strict in-order dispatch: the head waits for its own channel only.
    assign w_pop         = !w_empty && !abort && (r_state[w_head.chan] == IDLE);

    sine_cmd_fifo #(.FIFO_DEPTH(FIFO_DEPTH)) u_fifo (
        .clk     (clk),
        .rst_n   (reset),
        .i_flush (abort),
        .i_push  (w_push),
        .i_din   (w_cmd),
        .i_pop   (w_pop),
        .o_dout  (w_head),
        .o_full  (w_full),
        .o_empty (w_empty)
    );

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) r_alive <= 1'b0;
        else        r_alive <= 1'b1;
    end

    // r_last names the channel granted most recently; a tie goes to the other.
    assign w_req[0]     = (r_state[0] == RUN);
    assign w_req[1]     = (r_state[1] == RUN);
    assign w_gnt[0]     = w_req[0] && (!w_req[1] || r_last);
    assign w_gnt[1]     = w_req[1] && (!w_req[0] || !r_last);
    assign bus.rom_en   = |w_gnt;
    assign bus.rom_addr = w_gnt[0] ? r_phase[0] : (w_gnt[1] ? r_phase[1] : '0);

    // DRAIN lasts exactly the cycle in which the last ROM word is in flight,
    // so done lines up with the final sample and the channel is IDLE again by then.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int c = 0; c < 2; c++) r_state[c] <= IDLE;
            r_phase <= '0;
            r_step  <= '0;
            r_rem   <= '0;
            r_done  <= '0;
        end else begin
            for (int c = 0; c < 2; c++) begin
                r_done[c] <= 1'b0;
                if (abort) begin
                    r_state[c] <= IDLE;
                end else begin
                    case (r_state[c])
                        IDLE: if (w_pop && (w_head.chan == 1'(c))) begin
                            r_phase[c] <= '0;
                            r_step[c]  <= w_head.step;
                            r_rem[c]   <= w_head.len;
                            r_state[c] <= (w_head.len == '0) ? DRAIN : RUN;
                        end
                        RUN: if (w_gnt[c]) begin
                            r_phase[c] <= r_phase[c] + r_step[c];
                            r_rem[c]   <= r_rem[c] - LEN_W'(1);
                            if (r_rem[c] == LEN_W'(1)) r_state[c] <= DRAIN;
                        end
                        DRAIN: begin
                            r_state[c] <= IDLE;
                            r_done[c]  <= 1'b1;
                        end
                        default: r_state[c] <= IDLE;
                    endcase
                end
            end
        end
    end

    // Grant -> ROM data valid -> registered sample; abort kills both stages.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_vld  <= '0;
            r_sv   <= '0;
            r_sine <= '0;
            r_last <= 1'b1;
        end else begin
            r_vld <= abort ? 2'b00 : w_gnt;
            r_sv  <= abort ? 2'b00 : r_vld;
            if (|w_gnt) r_last <= w_gnt[1];
            for (int c = 0; c < 2; c++) begin
                if (r_vld[c] && !abort) r_sine[c] <= bus.rom_data;
            end
        end
    end

    assign sine_out0     = r_sine[0];
    assign sine_out1     = r_sine[1];
    assign sample_valid0 = r_sv[0];
    assign sample_valid1 = r_sv[1];
    assign done0         = r_done[0];
    assign done1         = r_done[1];
    assign busy0         = (r_state[0] != IDLE) || r_done[0];
    assign busy1         = (r_state[1] != IDLE) || r_done[1];
endmodule
